// File: rtl/value_to_pay_fsm.sv
// value_to_pay_fsm: turns client-select and time-button presses into the
// 5-bit euro amount consumed by the check-digit stage.
module value_to_pay_fsm #(
  parameter int unsigned RATE_A      = 2,
  parameter int unsigned RATE_B      = 4,
  parameter int unsigned MAX_UNITS_A = 8,
  parameter int unsigned MAX_UNITS_B = 7,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clientA,
  input  logic       clientB,
  input  logic       timeBtn,
  input  logic       confirm,
  input  logic       cancel,
  output logic [4:0] valueToPay,
  output logic       valueValid,
  output logic [3:0] units,
  output logic       selErr
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]    RA       = 5'(RATE_A);
  localparam logic [4:0]    RB       = 5'(RATE_B);
  localparam logic [3:0]    MA       = 4'(MAX_UNITS_A);
  localparam logic [3:0]    MB       = 4'(MAX_UNITS_B);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_COUNT, S_DONE} state_t;

  state_t        r_state, w_state_n;
  logic          r_client, w_client_n;     // 0 = client A, 1 = client B
  logic [3:0]    r_units, w_units_n;
  logic [4:0]    r_value, w_value_n;
  logic          r_sel_err, w_sel_err_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          r_a_d, r_b_d, r_t_d, r_c_d, r_k_d;
  logic          w_pa, w_pb, w_pt, w_pc, w_pk, w_any, w_abort;
  logic [4:0]    w_rate, w_value;
  logic [3:0]    w_max;

  assign w_pa  = clientA & ~r_a_d;
  assign w_pb  = clientB & ~r_b_d;
  assign w_pt  = timeBtn & ~r_t_d;
  assign w_pc  = confirm & ~r_c_d;
  assign w_pk  = cancel  & ~r_k_d;
  assign w_any = w_pa | w_pb | w_pt | w_pc | w_pk;

  assign w_rate  = r_client ? RB : RA;
  assign w_max   = r_client ? MB : MA;
  assign w_value = 5'(r_units) * w_rate;

  // State, datapath and button-history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_client  <= 1'b0;
      r_units   <= '0;
      r_value   <= '0;
      r_sel_err <= 1'b0;
      r_tmo     <= '0;
      r_a_d     <= 1'b0;
      r_b_d     <= 1'b0;
      r_t_d     <= 1'b0;
      r_c_d     <= 1'b0;
      r_k_d     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_client  <= w_client_n;
      r_units   <= w_units_n;
      r_value   <= w_value_n;
      r_sel_err <= w_sel_err_n;
      r_tmo     <= w_tmo_n;
      r_a_d     <= clientA;
      r_b_d     <= clientB;
      r_t_d     <= timeBtn;
      r_c_d     <= confirm;
      r_k_d     <= cancel;
    end
  end

  // Next-state logic; cancel and timeout share one abort path back to IDLE
  always_comb begin
    w_state_n   = r_state;
    w_client_n  = r_client;
    w_units_n   = r_units;
    w_value_n   = r_value;
    w_sel_err_n = 1'b0;
    w_abort     = 1'b0;
    w_tmo_n     = ((r_state == S_SELECT || r_state == S_COUNT) && !w_any)
                  ? r_tmo + 1'b1 : '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pa && w_pb) begin
          w_sel_err_n = 1'b1;
        end else if (w_pa || w_pb) begin
          w_client_n = w_pb;
          w_state_n  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_pk) begin
          w_abort = 1'b1;
        end else begin
          if (r_client ? w_pa : w_pb) w_sel_err_n = 1'b1;
          if (w_pt) begin
            w_units_n = 4'd1;
            w_state_n = S_COUNT;
          end else if (!w_any && r_tmo == TMO_LAST) begin
            w_abort = 1'b1;
          end
        end
      end
      S_COUNT: begin
        // confirm takes priority over a timeBtn press in the same cycle
        if (w_pk) begin
          w_abort = 1'b1;
        end else if (w_pc) begin
          w_value_n = w_value;
          w_state_n = S_DONE;
        end else if (w_pt) begin
          if (r_units < w_max) w_units_n = r_units + 4'd1;
        end else if (!w_any && r_tmo == TMO_LAST) begin
          w_abort = 1'b1;
        end
      end
      S_DONE: begin
        if (w_pk) w_abort = 1'b1;
      end
      default: w_abort = 1'b1;
    endcase
    if (w_abort) begin
      w_state_n = S_IDLE;
      w_units_n = '0;
      w_value_n = '0;
      w_tmo_n   = '0;
    end
  end

  assign valueToPay = r_value;
  assign valueValid = (r_state == S_DONE);
  assign units      = r_units;
  assign selErr     = r_sel_err;

endmodule

// File: tb/tb_value_to_pay_fsm.sv
// Testbench for value_to_pay_fsm: directed scenarios followed by random
// button activity, all outputs compared every cycle with a reference model.
module tb_value_to_pay_fsm;

  localparam int TMO = 16;

  logic       clk, rst_n;
  logic       clientA, clientB, timeBtn, confirm, cancel;
  logic [4:0] valueToPay;
  logic       valueValid;
  logic [3:0] units;
  logic       selErr;

  int n_assert = 0;
  int n_fail   = 0;

  value_to_pay_fsm #(
    .RATE_A(2), .RATE_B(4), .MAX_UNITS_A(8), .MAX_UNITS_B(7), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clientA(clientA), .clientB(clientB),
    .timeBtn(timeBtn), .confirm(confirm), .cancel(cancel),
    .valueToPay(valueToPay), .valueValid(valueValid), .units(units), .selErr(selErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase 0 idle, 1 client chosen, 2 counting, 3 amount shown
  int m_phase, m_client, m_units, m_idle, m_value, m_selerr;
  bit h_a, h_b, h_t, h_c, h_k;

  function automatic void model_reset();
    m_phase = 0; m_client = 0; m_units = 0; m_idle = 0; m_value = 0; m_selerr = 0;
    h_a = 0; h_b = 0; h_t = 0; h_c = 0; h_k = 0;
  endfunction

  function automatic void model_abort();
    m_phase = 0; m_units = 0; m_value = 0; m_idle = 0;
  endfunction

  function automatic void model_step();
    bit pa, pb, pt, pc, pk, any;
    int rate, cap;
    pa = clientA && !h_a; pb = clientB && !h_b; pt = timeBtn && !h_t;
    pc = confirm && !h_c; pk = cancel && !h_k;
    h_a = clientA; h_b = clientB; h_t = timeBtn; h_c = confirm; h_k = cancel;
    any = pa | pb | pt | pc | pk;
    rate = (m_client == 1) ? 4 : 2;
    cap  = (m_client == 1) ? 7 : 8;
    m_selerr = 0;
    if (m_phase == 1 || m_phase == 2) begin
      if (any) m_idle = 0; else m_idle++;
    end else begin
      m_idle = 0;
    end
    case (m_phase)
      0: begin
        if (pa && pb) m_selerr = 1;
        else if (pa) begin m_client = 0; m_phase = 1; end
        else if (pb) begin m_client = 1; m_phase = 1; end
      end
      1: begin
        if (pk) model_abort();
        else begin
          if ((m_client == 0 && pb) || (m_client == 1 && pa)) m_selerr = 1;
          if (pt) begin m_units = 1; m_phase = 2; end
          else if (m_idle == TMO) model_abort();
        end
      end
      2: begin
        if (pk) model_abort();
        else if (pc) begin m_value = m_units * rate; m_phase = 3; end
        else if (pt) begin if (m_units < cap) m_units++; end
        else if (m_idle == TMO) model_abort();
      end
      default: if (pk) model_abort();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".value"}, {27'd0, valueToPay}, (m_phase == 3) ? m_value : 0);
    chk({tag, ".valid"}, {31'd0, valueValid}, (m_phase == 3) ? 1 : 0);
    chk({tag, ".units"}, {28'd0, units}, m_units);
    chk({tag, ".selErr"}, {31'd0, selErr}, m_selerr);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: clientA = v;
      1: clientB = v;
      2: timeBtn = v;
      3: confirm = v;
      default: cancel = v;
    endcase
  endtask

  task automatic press(input int which, input string tag);
    set_btn(which, 1'b1);
    tick(tag);
    set_btn(which, 1'b0);
    tick(tag);
  endtask

  initial begin
    clientA = 0; clientB = 0; timeBtn = 0; confirm = 0; cancel = 0;
    rst_n = 1'b1;
    model_reset();
    #3 rst_n = 1'b0;
    #5;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_reset");

    // 1: client A, three units, confirm -> 6 euros
    press(0, "t1");
    for (int i = 0; i < 3; i++) press(2, "t1");
    confirm = 1'b1; tick("t1");
    chk("t1.value6", {27'd0, valueToPay}, 6);
    chk("t1.units3", {28'd0, units}, 3);
    chk("t1.valid", {31'd0, valueValid}, 1);
    confirm = 1'b0; tick("t1");
    press(4, "t1.cancel");
    chk("t1.cleared", {27'd0, valueToPay}, 0);

    // 2: client B, ten time presses saturate at 7 -> 28 euros
    press(1, "t2");
    for (int i = 0; i < 10; i++) press(2, "t2");
    chk("t2.sat", {28'd0, units}, 7);
    press(3, "t2");
    chk("t2.value28", {27'd0, valueToPay}, 28);
    press(4, "t2.cancel");

    // 3: both clients at once in IDLE
    clientA = 1'b1; clientB = 1'b1; tick("t3");
    chk("t3.selErr", {31'd0, selErr}, 1);
    clientA = 1'b0; clientB = 1'b0; tick("t3");
    chk("t3.pulse", {31'd0, selErr}, 0);
    chk("t3.value0", {27'd0, valueToPay}, 0);

    // 4: confirm with no units is not payable, then cancel
    press(0, "t4");
    press(3, "t4");
    chk("t4.novalid", {31'd0, valueValid}, 0);
    press(1, "t4.other");
    press(4, "t4.cancel");
    press(2, "t4.idle_time");
    chk("t4.idle_units", {28'd0, units}, 0);

    // 5: inactivity timeout from COUNT
    press(1, "t5");
    press(2, "t5");
    press(2, "t5");
    chk("t5.units2", {28'd0, units}, 2);
    for (int i = 0; i < TMO; i++) tick("t5.wait");
    chk("t5.units0", {28'd0, units}, 0);
    chk("t5.value0", {27'd0, valueToPay}, 0);

    // 6: held timeBtn counts once; async reset while showing 16
    press(0, "t6");
    timeBtn = 1'b1;
    for (int i = 0; i < 5; i++) tick("t6.hold");
    chk("t6.held1", {28'd0, units}, 1);
    timeBtn = 1'b0; tick("t6");
    for (int i = 0; i < 7; i++) press(2, "t6");
    press(3, "t6");
    chk("t6.value16", {27'd0, valueToPay}, 16);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.async_value", {27'd0, valueToPay}, 0);
    chk("t6.async_valid", {31'd0, valueValid}, 0);
    chk("t6.async_units", {28'd0, units}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("t6.after");

    // Random button activity with periodic quiet stretches to reach timeouts
    for (int i = 0; i < 3000; i++) begin
      if ((i % 250) >= 200 && (i % 250) < 230) begin
        clientA = 0; clientB = 0; timeBtn = 0; confirm = 0; cancel = 0;
      end else begin
        if ($urandom_range(0, 5) == 0) clientA = ~clientA;
        if ($urandom_range(0, 5) == 0) clientB = ~clientB;
        if ($urandom_range(0, 2) == 0) timeBtn = ~timeBtn;
        if ($urandom_range(0, 7) == 0) confirm = ~confirm;
        if ($urandom_range(0, 19) == 0) cancel = ~cancel;
      end
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
